// File: rtl/dds_core_if.sv
// AXI-Stream style handshake bundle used for the increment input and the sample output.
//   data  : payload, DWIDTH bits
//   valid : source has a beat
//   ready : sink accepts the beat
//   last  : end-of-packet marker
interface dds_core_if #(
  parameter int unsigned DWIDTH = 8
);
  logic [DWIDTH-1:0] data;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/dds_core.sv
// Direct digital synthesizer: emits PARALLEL_SAMPLES consecutive cosine samples per clock.
//   clk          : single clock
//   reset        : asynchronous, active-low
//   phase_inc_in : slave stream, phase increment per sample (PHASE_BITS wide)
//   cos_out      : master stream, lane k in data[k*OUTPUT_WIDTH +: OUTPUT_WIDTH], lane 0 earliest
// Four-stage pipeline (phase, LUT address, LUT data, output) advanced by one global enable.
module dds_core #(
  parameter int unsigned PHASE_BITS       = 24,
  parameter int unsigned OUTPUT_WIDTH     = 18,
  parameter int unsigned QUANT_BITS       = 8,
  parameter int unsigned PARALLEL_SAMPLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  dds_core_if.slave   phase_inc_in,
  dds_core_if.master  cos_out
);
  localparam int unsigned P           = PARALLEL_SAMPLES;
  localparam int unsigned LutAddrBits = PHASE_BITS - QUANT_BITS;
  localparam int unsigned LutDepth    = 2 ** LutAddrBits;
  // The ROM is split into small blocks so each constant function call stays short.
  // LutAddrBits must exceed BlkBits.
  localparam int unsigned BlkBits     = 6;
  localparam int unsigned BlkDepth    = 2 ** BlkBits;
  localparam int unsigned NumBlks     = LutDepth / BlkDepth;
  localparam real         Pi          = 3.14159265358979323846;

  function automatic logic [BlkDepth*OUTPUT_WIDTH-1:0] gen_blk(input int unsigned blk);
    logic [BlkDepth*OUTPUT_WIDTH-1:0] bits;
    real    amp;
    real    x;
    longint v;
    longint max_v;
    longint min_v;
    max_v = (longint'(1) << (OUTPUT_WIDTH - 1)) - 1;
    min_v = -(longint'(1) << (OUTPUT_WIDTH - 1));
    amp   = (2.0 ** (OUTPUT_WIDTH - 1)) - 0.5;
    bits  = '0;
    for (int unsigned i = 0; i < BlkDepth; i++) begin
      x = amp * $cos(2.0 * Pi * real'(blk * BlkDepth + i) / real'(LutDepth)) - 0.5;
      v = longint'($floor(x));
      if (v > max_v) v = max_v;
      if (v < min_v) v = min_v;
      bits[i*OUTPUT_WIDTH +: OUTPUT_WIDTH] = v[OUTPUT_WIDTH-1:0];
    end
    return bits;
  endfunction

  logic [BlkDepth*OUTPUT_WIDTH-1:0] rom [NumBlks];

  for (genvar b = 0; b < NumBlks; b++) begin : g_rom
    localparam logic [BlkDepth*OUTPUT_WIDTH-1:0] RomWord = gen_blk(b);
    assign rom[b] = RomWord;
  end

  logic                    ready_q;
  logic                    en;
  logic [PHASE_BITS-1:0]   acc_q, acc_d;
  logic [PHASE_BITS-1:0]   inc_q, inc_d;
  logic [PHASE_BITS-1:0]   lane_sum [P];
  logic [PHASE_BITS-1:0]   phase_q [P];
  logic [PHASE_BITS-1:0]   phase_d [P];
  logic [LutAddrBits-1:0]  addr_q [P];
  logic [LutAddrBits-1:0]  addr_d [P];
  logic [OUTPUT_WIDTH-1:0] lut_q [P];
  logic [OUTPUT_WIDTH-1:0] lut_d [P];
  logic [OUTPUT_WIDTH*P-1:0] data_q, data_d;
  logic [3:0]              valid_q, valid_d;
  logic                    unused_sink;

  always_comb begin
    // A stalled output freezes every stage so no beat is lost or repeated.
    en = !valid_q[3] || cos_out.ready;

    inc_d = inc_q;
    if (phase_inc_in.valid && ready_q) inc_d = phase_inc_in.data;

    // Lane phases as a running sum: A, A+I, A+2I, ... (adders only).
    lane_sum[0] = acc_q;
    for (int k = 1; k < P; k++) lane_sum[k] = lane_sum[k-1] + inc_q;

    acc_d   = acc_q;
    phase_d = phase_q;
    addr_d  = addr_q;
    lut_d   = lut_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (en) begin
      acc_d   = lane_sum[P-1] + inc_q;
      phase_d = lane_sum;
      for (int k = 0; k < P; k++) begin
        addr_d[k] = phase_q[k][PHASE_BITS-1:QUANT_BITS];
        lut_d[k]  = rom[addr_q[k][LutAddrBits-1:BlkBits]]
                       [addr_q[k][BlkBits-1:0]*OUTPUT_WIDTH +: OUTPUT_WIDTH];
        data_d[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] = lut_q[k];
      end
      valid_d = {valid_q[2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b0;
      acc_q   <= '0;
      inc_q   <= '0;
      phase_q <= '{default: '0};
      addr_q  <= '{default: '0};
      lut_q   <= '{default: '0};
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      ready_q <= 1'b1;
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      lut_q   <= lut_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign phase_inc_in.ready = ready_q;
  assign cos_out.data       = data_q;
  assign cos_out.valid      = valid_q[3];
  assign cos_out.last       = 1'b0;

  // Phase LSBs below the LUT resolution and the input last flag carry no information here.
  always_comb begin
    unused_sink = phase_inc_in.last;
    for (int k = 0; k < P; k++) unused_sink = unused_sink ^ (^phase_q[k][QUANT_BITS-1:0]);
  end
endmodule

// File: tb/tb_dds_core.sv
module tb_dds_core;
  localparam int unsigned PB = 24;
  localparam int unsigned OW = 18;
  localparam int unsigned QB = 8;
  localparam int unsigned P  = 4;
  localparam real         Pi = 3.14159265358979323846;

  typedef struct {
    logic [PB-1:0] inc;
    int            stall;
    int            toggle;
    int            run;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dds_core_if #(.DWIDTH(PB))   inc_if ();
  dds_core_if #(.DWIDTH(OW*P)) out_if ();

  dds_core #(
    .PHASE_BITS      (PB),
    .OUTPUT_WIDTH    (OW),
    .QUANT_BITS      (QB),
    .PARALLEL_SAMPLES(P)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .phase_inc_in(inc_if),
    .cos_out     (out_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what S0 will generate, and the beats already in flight.
  logic [PB-1:0]   m_acc;
  logic [PB-1:0]   m_inc;
  int              m_fill;
  int              const_left;
  logic [P*PB-1:0] sb [$];
  logic [P*OW-1:0] const_beat;
  vec_t            vecs [3];

  function automatic int cos_val(input logic [PB-1:0] ph, input bit trunc);
    real    ang;
    real    x;
    longint v;
    ang = trunc ? real'(ph >> QB) / real'(2 ** (PB - QB)) : real'(ph) / real'(2 ** PB);
    x   = 131071.5 * $cos(2.0 * Pi * ang) - 0.5;
    v   = longint'($floor(x));
    if (v > 131071) v = 131071;
    if (v < -131072) v = -131072;
    return int'(v);
  endfunction

  task automatic check(input string name, input logic [P*OW-1:0] act, input logic [P*OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc      = '0;
    m_inc      = '0;
    m_fill     = 0;
    const_left = 0;
    sb.delete();
  endtask

  // Called at a negedge with inputs already set: checks outputs, predicts the next posedge.
  task automatic tick();
    logic            mv;
    logic [P*PB-1:0] ph;
    logic [P*OW-1:0] exp_beat;
    int              err;
    int              max_err;
    int              lane;
    mv = (m_fill == 4);
    check("out_valid", P*OW'(out_if.valid), P*OW'(mv));
    check("inc_ready", P*OW'(inc_if.ready), P*OW'(m_fill != 0));
    if (mv && out_if.ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: output beat with no expected entry");
      end else begin
        ph = sb.pop_front();
        max_err = 0;
        for (int k = 0; k < P; k++) begin
          exp_beat[k*OW +: OW] = OW'(cos_val(ph[k*PB +: PB], 1'b1));
          lane = int'($signed(out_if.data[k*OW +: OW]));
          err  = lane - cos_val(ph[k*PB +: PB], 1'b0);
          if (err < 0) err = -err;
          if (err > max_err) max_err = err;
        end
        check("beat", out_if.data, exp_beat);
        n_checks++;
        if (max_err > 15) begin
          n_fail++;
          $display("FAIL accuracy: error %0d LSB, expected <= 15", max_err);
        end
        if (const_left > 0) begin
          check("const_beat", out_if.data, const_beat);
          const_left--;
        end
      end
    end
    if (!mv || out_if.ready) begin
      for (int k = 0; k < P; k++) ph[k*PB +: PB] = m_acc + PB'(k) * m_inc;
      sb.push_back(ph);
      m_acc = m_acc + PB'(P) * m_inc;
      if (m_fill < 4) m_fill++;
    end
    if (inc_if.valid && m_fill != 0) m_inc = inc_if.data;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_inc(input logic [PB-1:0] v);
    inc_if.valid = 1'b1;
    inc_if.data  = v;
    tick();
    inc_if.valid = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < P; k++) const_beat[k*OW +: OW] = 18'h1FFFF;
    vecs[0] = '{inc: 24'd1355379, stall: 10, toggle: 100, run: 20};
    vecs[1] = '{inc: 24'd4534380, stall: 5,  toggle: 0,   run: 60};
    vecs[2] = '{inc: 24'd7232,    stall: 50, toggle: 0,   run: 40};

    reset        = 1'b1;
    inc_if.valid = 1'b0;
    inc_if.data  = '0;
    inc_if.last  = 1'b0;
    out_if.ready = 1'b0;
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", P*OW'(out_if.valid), '0);
    check("rst_data", out_if.data, '0);
    check("rst_last", P*OW'(out_if.last), '0);
    model_reset();
    reset = 1'b1;

    // Stall from reset: pipeline fills and holds; then drain constant beats with I=0.
    repeat (20) tick();
    out_if.ready = 1'b1;
    const_left = 8;
    repeat (8) tick();

    // Increment written during a full stall: next 4 beats still carry the old increment (0).
    out_if.ready = 1'b0;
    repeat (2) tick();
    write_inc(24'd31798);
    repeat (100) tick();
    out_if.ready = 1'b1;
    const_left = 4;
    repeat (30) tick();

    for (int i = 0; i < 3; i++) begin
      out_if.ready = 1'b0;
      repeat (2) tick();
      write_inc(vecs[i].inc);
      repeat (vecs[i].stall) tick();
      for (int c = 0; c < vecs[i].toggle; c++) begin
        out_if.ready = 1'($urandom_range(0, 1));
        tick();
      end
      out_if.ready = 1'b1;
      repeat (vecs[i].run) tick();
    end

    // Asynchronous reset mid-stream: output drops at once, restarts from phase 0 with I=0.
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", P*OW'(out_if.valid), '0);
    check("midrst_data", out_if.data, '0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    reset = 1'b1;
    const_left = 3;
    repeat (10) tick();
    check("last_low", P*OW'(out_if.last), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
